// File: rtl/nios_accelerometer_cpu_debug_cmd_bridge_pkg.sv
// Shared types, default widths and helpers for the debug command bridge.
// Optional parity: NIOS_DEBUG_CMD_BRIDGE_PARITY_EN.
package nios_debug_pkg;

   typedef enum logic {
      IDLE,
      PEND
   } state_e;

   localparam int DR_WIDTH_DEF = 38;
   localparam int IR_WIDTH_DEF = 2;

   function automatic int slice_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/nios_accelerometer_cpu_debug_cmd_bridge_if.sv
// Command valid/ready bundle between the bridge and its debug targets.
// One-hot valid, shared payload, per-target ready.
interface nios_accelerometer_cpu_debug_cmd_bridge_if #(
   parameter int DR_WIDTH = 38,
   parameter int NUM_CH   = 4
);

   logic [DR_WIDTH-1:0] cmd_data;
   logic [NUM_CH-1:0]   cmd_valid;
   logic [NUM_CH-1:0]   cmd_ready;

   modport master (
      output cmd_data,
      output cmd_valid,
      input  cmd_ready
   );

   modport slave (
      input  cmd_data,
      input  cmd_valid,
      output cmd_ready
   );

endinterface

// File: rtl/nios_accelerometer_cpu_debug_cmd_bridge_shifter.sv
// Scan shift register, bit counter, capture mux and parity for the bridge.
// Parity bit present when NIOS_DEBUG_CMD_BRIDGE_PARITY_EN is defined.
module nios_debug_scan_shifter
   import nios_debug_pkg::*;
#(
   parameter int DR_WIDTH = DR_WIDTH_DEF,
   parameter int NUM_CH   = 4,
   parameter int IR_WIDTH = IR_WIDTH_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [IR_WIDTH-1:0]        ir_in,
   input  logic                       cdr,
   input  logic                       sdr,
   input  logic                       udr,
   input  logic                       tdi,
   input  logic [NUM_CH*DR_WIDTH-1:0] rd_data,
   output logic                       tdo,
   output logic [DR_WIDTH-1:0]        sr_data,
`ifdef NIOS_DEBUG_CMD_BRIDGE_PARITY_EN
   output logic                       par_ok,
`endif
   output logic                       len_ok
);

`ifdef NIOS_DEBUG_CMD_BRIDGE_PARITY_EN
   localparam int SRW = DR_WIDTH + 1;
`else
   localparam int SRW = DR_WIDTH;
`endif
   localparam int CW = $clog2(SRW + 2);

   logic [SRW-1:0]      sr_q, sr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [DR_WIDTH-1:0] cap;
   logic [SRW-1:0]      cap_w;

   // Unmapped targets leave cap at zero.
   always_comb begin
      cap = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ir_in == IR_WIDTH'(k)) begin
            cap = rd_data[slice_lo(k, DR_WIDTH) +: DR_WIDTH];
         end
      end
   end

`ifdef NIOS_DEBUG_CMD_BRIDGE_PARITY_EN
   assign cap_w  = {^cap, cap};
   assign par_ok = (sr_q[DR_WIDTH] == ^sr_q[DR_WIDTH-1:0]);
`else
   assign cap_w  = cap;
`endif

   // An update freezes the scan path for that cycle.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (!udr) begin
         if (sdr) begin
            sr_d = {tdi, sr_q[SRW-1:1]};
            if (cnt_q != CW'(SRW + 1)) begin
               cnt_d = cnt_q + CW'(1);
            end
         end else if (cdr) begin
            sr_d  = cap_w;
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign tdo     = sr_q[0];
   assign sr_data = sr_q[DR_WIDTH-1:0];
   assign len_ok  = (cnt_q == CW'(SRW));

endmodule

// File: rtl/nios_accelerometer_cpu_debug_cmd_bridge.sv
// Debug command bridge: scan path into a one-hot valid/ready command.
// Optional parity: NIOS_DEBUG_CMD_BRIDGE_PARITY_EN.
module nios_accelerometer_cpu_debug_cmd_bridge
   import nios_debug_pkg::*;
#(
   parameter int DR_WIDTH = DR_WIDTH_DEF,
   parameter int NUM_CH   = 4,
   parameter int IR_WIDTH = IR_WIDTH_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [IR_WIDTH-1:0]        ir_in,
   input  logic                       cdr,
   input  logic                       sdr,
   input  logic                       udr,
   input  logic                       tdi,
   output logic                       tdo,
   input  logic [NUM_CH*DR_WIDTH-1:0] rd_data,
   nios_accelerometer_cpu_debug_cmd_bridge_if.master cmd,
   output logic                       overrun,
   output logic                       len_err,
   output logic                       parity_err
);

   logic [DR_WIDTH-1:0] sr_data;
   logic                len_ok;
   logic                par_ok;
   logic                ir_ok;
   logic                rdy;

   state_e              state_q, state_d;
   logic [IR_WIDTH-1:0] ch_q, ch_d;
   logic [DR_WIDTH-1:0] data_q, data_d;
   logic [NUM_CH-1:0]   valid_q, valid_d;
   logic                over_q, over_d;
   logic                len_q, len_d;
   logic                par_q, par_d;

   nios_debug_scan_shifter #(
      .DR_WIDTH (DR_WIDTH),
      .NUM_CH   (NUM_CH),
      .IR_WIDTH (IR_WIDTH)
   ) u_shift (
      .clk     (clk),
      .reset   (reset),
      .ir_in   (ir_in),
      .cdr     (cdr),
      .sdr     (sdr),
      .udr     (udr),
      .tdi     (tdi),
      .rd_data (rd_data),
      .tdo     (tdo),
      .sr_data (sr_data),
`ifdef NIOS_DEBUG_CMD_BRIDGE_PARITY_EN
      .par_ok  (par_ok),
`endif
      .len_ok  (len_ok)
   );

`ifndef NIOS_DEBUG_CMD_BRIDGE_PARITY_EN
   assign par_ok = 1'b1;
`endif

   assign ir_ok = (int'(ir_in) < NUM_CH);
   assign rdy   = |(cmd.cmd_ready & (NUM_CH'(1) << ch_q));

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      data_d  = data_q;
      valid_d = valid_q;
      over_d  = over_q;
      len_d   = 1'b0;
      par_d   = 1'b0;
      if (udr && !len_ok) begin
         len_d = 1'b1;
      end
      unique case (state_q)
         IDLE: begin
            if (udr && len_ok && ir_ok) begin
               if (!par_ok) begin
                  par_d = 1'b1;
               end else begin
                  data_d  = sr_data;
                  valid_d = NUM_CH'(1) << ir_in;
                  ch_d    = ir_in;
                  state_d = PEND;
               end
            end
         end
         PEND: begin
            // The pending command wins; any new update is dropped.
            if (udr) begin
               over_d = 1'b1;
            end
            if (rdy) begin
               valid_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ch_q    <= '0;
         data_q  <= '0;
         valid_q <= '0;
         over_q  <= 1'b0;
         len_q   <= 1'b0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         over_q  <= over_d;
         len_q   <= len_d;
         par_q   <= par_d;
      end
   end

   assign cmd.cmd_data  = data_q;
   assign cmd.cmd_valid = valid_q;
   assign overrun       = over_q;
   assign len_err       = len_q;
`ifdef NIOS_DEBUG_CMD_BRIDGE_PARITY_EN
   assign parity_err    = par_q;
`else
   assign parity_err    = 1'b0;
   logic unused_par;
   assign unused_par    = par_q;
`endif

endmodule

// File: tb/tb_nios_accelerometer_cpu_debug_cmd_bridge.sv
// Bench for the debug command bridge: vector table, corner sequences,
// and a randomized run against a behavioural model.
module tb_nios_accelerometer_cpu_debug_cmd_bridge;

   localparam int DW = 8;
   localparam int NC = 4;
   localparam int IW = 2;
`ifdef NIOS_DEBUG_CMD_BRIDGE_PARITY_EN
   localparam int SRW = DW + 1;
`else
   localparam int SRW = DW;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [IW-1:0] ir_in;
   logic          cdr, sdr, udr, tdi;
   logic          tdo;
   logic [NC*DW-1:0] rd_data;
   logic          overrun, len_err, parity_err;

   nios_accelerometer_cpu_debug_cmd_bridge_if #(.DR_WIDTH(DW), .NUM_CH(NC)) cif ();

   nios_accelerometer_cpu_debug_cmd_bridge #(
      .DR_WIDTH (DW),
      .NUM_CH   (NC),
      .IR_WIDTH (IW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ir_in      (ir_in),
      .cdr        (cdr),
      .sdr        (sdr),
      .udr        (udr),
      .tdi        (tdi),
      .tdo        (tdo),
      .rd_data    (rd_data),
      .cmd        (cif.master),
      .overrun    (overrun),
      .len_err    (len_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic c, input logic s, input logic u,
                        input logic t, input logic [IW-1:0] ir,
                        input logic [NC-1:0] rdy);
      cdr = c; sdr = s; udr = u; tdi = t; ir_in = ir;
      cif.cmd_ready = rdy;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic scan(input logic [IW-1:0] ir, input logic [SRW-1:0] v);
      drive(1, 0, 0, 0, ir, 0);
      tick();
      for (int i = 0; i < SRW; i++) begin
         drive(0, 1, 0, v[i], ir, 0);
         tick();
      end
      idle();
   endtask

   typedef struct {
      logic          c, s, u, t;
      logic [IW-1:0] ir;
      logic [NC-1:0] rdy;
      logic          e_tdo;
      logic [NC-1:0] e_valid;
      logic [DW-1:0] e_data;
      logic          e_len;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic c, input logic s, input logic u,
                               input logic t, input logic [IW-1:0] ir,
                               input logic [NC-1:0] rdy, input logic e_tdo,
                               input logic [NC-1:0] e_valid,
                               input logic [DW-1:0] e_data, input logic e_len);
      vec_t v;
      v.c = c; v.s = s; v.u = u; v.t = t; v.ir = ir; v.rdy = rdy;
      v.e_tdo = e_tdo; v.e_valid = e_valid; v.e_data = e_data; v.e_len = e_len;
      return v;
   endfunction

   logic [SRW-1:0] m_sr;
   int             m_cnt;
   bit             m_pend;
   int             m_ch;
   logic [DW-1:0]  m_data;
   bit             m_over;

   initial begin
      reset = 1'b1;
      idle();
      rd_data = {8'h33, 8'hA5, 8'h22, 8'h11};
      tick();
      tick();
      check("rst_tdo", tdo, 0);
      check("rst_valid", cif.cmd_valid, 0);
      check("rst_data", cif.cmd_data, 0);
      check("rst_overrun", overrun, 0);
      check("rst_len_err", len_err, 0);
      check("rst_parity_err", parity_err, 0);
      reset = 1'b0;

`ifndef NIOS_DEBUG_CMD_BRIDGE_PARITY_EN
      tbl.push_back(mk(1, 0, 0, 0, 2, 0, 1, 0, 8'h00, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2, 0, 1, 0, 8'h00, 0));
      tbl.push_back(mk(0, 1, 0, 1, 2, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(0, 1, 0, 1, 2, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(0, 1, 0, 1, 2, 0, 1, 0, 8'h00, 0));
      tbl.push_back(mk(0, 1, 0, 1, 2, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2, 0, 1, 0, 8'h00, 0));
      tbl.push_back(mk(0, 1, 0, 0, 2, 0, 0, 0, 8'h00, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 4'b0010, 8'h3C, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 4'b0010, 8'h3C, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 4'b1101, 0, 4'b0010, 8'h3C, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 4'b0010, 0, 4'b0000, 8'h3C, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 8'h3C, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 8'h3C, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 8'h3C, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 8'h3C, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 8'h3C, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 8'h3C, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 8'h3C, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 8'h3C, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 8'h3C, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 8'h3C, 0));

      foreach (tbl[i]) begin
         drive(tbl[i].c, tbl[i].s, tbl[i].u, tbl[i].t, tbl[i].ir, tbl[i].rdy);
         tick();
         check($sformatf("vec%0d_tdo", i), tdo, tbl[i].e_tdo);
         check($sformatf("vec%0d_valid", i), cif.cmd_valid, tbl[i].e_valid);
         check($sformatf("vec%0d_data", i), cif.cmd_data, tbl[i].e_data);
         check($sformatf("vec%0d_len", i), len_err, tbl[i].e_len);
      end
      idle();

      scan(0, 8'h5A);
      drive(0, 0, 1, 0, 0, 0);
      tick();
      check("ovr_first_valid", cif.cmd_valid, 4'b0001);
      check("ovr_first_data", cif.cmd_data, 8'h5A);
      check("ovr_first_flag", overrun, 0);
      scan(1, 8'hA5);
      check("ovr_held_valid", cif.cmd_valid, 4'b0001);
      drive(0, 0, 1, 0, 1, 0);
      tick();
      check("ovr_set", overrun, 1);
      check("ovr_valid_kept", cif.cmd_valid, 4'b0001);
      check("ovr_data_kept", cif.cmd_data, 8'h5A);
      check("ovr_no_len", len_err, 0);
      drive(0, 0, 0, 0, 0, 4'b0001);
      tick();
      check("ovr_hs_valid", cif.cmd_valid, 0);
      idle();
      repeat (3) tick();
      check("ovr_sticky", overrun, 1);

      drive(0, 1, 1, 0, 3, 0);
      tick();
      check("simul_valid", cif.cmd_valid, 4'b1000);
      check("simul_data", cif.cmd_data, 8'hA5);
      check("simul_tdo_hold", tdo, 1);
      drive(0, 0, 0, 0, 0, 4'b1000);
      tick();
      check("simul_hs", cif.cmd_valid, 0);
      drive(0, 0, 1, 0, 2, 0);
      tick();
      check("simul_cnt_hold", cif.cmd_valid, 4'b0100);
      check("simul_cnt_len", len_err, 0);
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("pend_rst_valid", cif.cmd_valid, 0);
      check("pend_rst_data", cif.cmd_data, 0);
      check("pend_rst_ovr", overrun, 0);
      check("pend_rst_tdo", tdo, 0);
      check("pend_rst_len", len_err, 0);
`else
      scan(0, 9'h001);
      drive(0, 0, 1, 0, 0, 0);
      tick();
      check("par_bad_err", parity_err, 1);
      check("par_bad_valid", cif.cmd_valid, 0);
      idle();
      tick();
      check("par_bad_pulse", parity_err, 0);
      scan(0, 9'h101);
      drive(0, 0, 1, 0, 0, 0);
      tick();
      check("par_good_err", parity_err, 0);
      check("par_good_valid", cif.cmd_valid, 4'b0001);
      check("par_good_data", cif.cmd_data, 8'h01);
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
`endif

      m_sr = '0; m_cnt = 0; m_pend = 0; m_ch = 0; m_data = '0; m_over = 0;
      for (int n = 0; n < 3000; n++) begin
         logic c, s, u, t, e_len, e_par, ok, lenok, parok;
         logic [IW-1:0] ir;
         logic [NC-1:0] rdy;
         logic [DW-1:0] slice;
         c   = ($urandom_range(0, 9) == 0);
         s   = ($urandom_range(0, 1) == 0);
         u   = ($urandom_range(0, 11) == 0);
         t   = 1'($urandom);
         ir  = IW'($urandom);
         rdy = ($urandom_range(0, 2) == 0) ? NC'($urandom) : '0;
         rd_data = NC*DW'($urandom);
         drive(c, s, u, t, ir, rdy);

         lenok = (m_cnt == SRW);
`ifdef NIOS_DEBUG_CMD_BRIDGE_PARITY_EN
         parok = (^m_sr == 1'b0);
`else
         parok = 1'b1;
`endif
         e_len = u && !lenok;
         e_par = 1'b0;
         ok = 1'b0;
         if (u && !m_pend && lenok) begin
            if (parok) ok = 1'b1;
            else e_par = 1'b1;
         end
         if (u && m_pend) m_over = 1;
         if (m_pend && rdy[m_ch]) m_pend = 0;
         if (ok) begin
            m_pend = 1;
            m_ch   = int'(ir);
            m_data = m_sr[DW-1:0];
         end
         if (!u && s) begin
            m_sr = (m_sr >> 1) | (SRW'(t) << (SRW - 1));
            if (m_cnt < SRW + 1) m_cnt++;
         end else if (!u && c) begin
            slice = rd_data[int'(ir)*DW +: DW];
`ifdef NIOS_DEBUG_CMD_BRIDGE_PARITY_EN
            m_sr = {^slice, slice};
`else
            m_sr = slice;
`endif
            m_cnt = 0;
         end

         tick();
         check("rnd_tdo", tdo, m_sr[0]);
         check("rnd_valid", cif.cmd_valid, m_pend ? (1 << m_ch) : 0);
         check("rnd_data", cif.cmd_data, m_data);
         check("rnd_ovr", overrun, m_over);
         check("rnd_len", len_err, e_len);
         check("rnd_par", parity_err, e_par);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nios_accelerometer_cpu_debug_cmd_bridge.md
# nios_accelerometer_cpu_debug_cmd_bridge

Parametrised single-clock debug command bridge for the CPU's debug slave. It replaces the fixed two-bit-IR, 38-bit scan path with configurable data-register width, target count and instruction width. Serial scan traffic, already synchronised into the system clock domain, is shifted into a data register, length-checked, and delivered as a valid/ready command to one of `NUM_CH` debug targets. On capture it loads per-target readback data for shift-out.

## Interface
- `DR_WIDTH`, 38: payload bits per scan (≥2).
- `NUM_CH`, 4: number of command targets (1..2^`IR_WIDTH`).
- `IR_WIDTH`, 2: instruction register width; `ir_in` selects the target.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `ir_in`  in  `IR_WIDTH`: target select, sampled on `cdr` and `udr`.
- `cdr`  in  1: capture-DR pulse, one cycle wide.
- `sdr`  in  1: shift-DR enable, one bit per asserted cycle.
- `udr`  in  1: update-DR pulse, one cycle wide.
- `tdi`  in  1: serial data in.
- `tdo`  out  1: serial data out; registered, equal to `sr[0]`.
- `rd_data`  in  `NUM_CH*DR_WIDTH`: per-target readback; slice `k` occupies bits `[k*DR_WIDTH +: DR_WIDTH]`.
- `cmd_data`  out  `DR_WIDTH`: command payload; stable while any `cmd_valid` bit is high.
- `cmd_valid`  out  `NUM_CH`: one-hot command valid.
- `cmd_ready`  in  `NUM_CH`: per-target accept.
- `overrun`  out  1: sticky. Set when an update is dropped because a command is still pending.
- `len_err`  out  1: one-cycle pulse when an update carries a bit count other than the expected length.
- `parity_err`  out  1: one-cycle pulse on a parity mismatch; constant 0 when parity is compiled out.

## Operation
- States:
  - `IDLE`: no command outstanding.
  - `PEND`: a command is outstanding, waiting for its target's `cmd_ready`.
- Shift register `sr` and bit counter `cnt` are active in both states, so a new scan can proceed while a command is pending.
- `cdr`:
  - `sr` ← `rd_data` slice for `ir_in`; all zeros if `ir_in` ≥ `NUM_CH`.
  - `cnt` ← 0.
- `sdr`:
  - `sr` ← {`tdi`, `sr[SRW-1:1]`}, where SRW is the shift-register width.
  - `cnt` ← `cnt`+1, saturating at SRW+1.
- `udr` in `IDLE`, with `cnt`==SRW, `ir_in` < `NUM_CH` and the parity check passing:
  - `cmd_data` ← `sr[DR_WIDTH-1:0]`.
  - `cmd_valid[ir_in]` ← 1.
  - Latch the channel index; go to `PEND`.
- `udr` failure cases:
  - `cnt` ≠ SRW: pulse `len_err`; no command is issued.
  - `ir_in` ≥ `NUM_CH`: silently ignored.
  - In `PEND`: set `overrun`; the command is dropped; the pending command is unchanged.
- `PEND`: when `cmd_ready[ch]` is high, clear `cmd_valid` and return to `IDLE`. Ready bits of other channels are ignored.
- Simultaneous strobes: priority is `udr` > `sdr` > `cdr`; lower-priority strobes in the same cycle are ignored.
- Reset values:
  - Outputs: `tdo`=0, `cmd_data`=0, `cmd_valid`=0, `overrun`=0, `len_err`=0, `parity_err`=0.
  - Internal: `sr`=0, `cnt`=0, state=`IDLE`.
- Reset asserted mid-scan or mid-`PEND` aborts the scan and drops the pending command without a handshake.
- `overrun` clears only on reset.

## Timing
- `tdo` shows the new `sr[0]` in the cycle after `cdr` or `sdr`.
- `cmd_valid` rises in the cycle after `udr`.
- The earliest a handshake can complete is that same cycle, if ready is already high; `cmd_valid` falls in the following cycle.
- A new `udr` arriving in the same cycle as a completing handshake counts as `PEND` and sets `overrun`.
- `len_err` and `parity_err` pulse in the cycle after `udr`, for exactly one cycle.
- Throughput is at most one command per two cycles.

## Configuration
- Macro: `NIOS_DEBUG_CMD_BRIDGE_PARITY_EN`.
- Defined:
  - SRW = `DR_WIDTH`+1.
  - `sr[DR_WIDTH]` is an even-parity bit over `sr[DR_WIDTH-1:0]`.
  - On a mismatch, the update pulses `parity_err` and issues no command.
  - On capture, the parity bit is loaded as the even parity of the readback slice.
- Undefined:
  - SRW = `DR_WIDTH`; no parity bit or parity check.
  - `parity_err` is tied to 0.

## Structure
- Shared package `nios_debug_pkg` holds:
  - The state enum (`IDLE`, `PEND`).
  - Default widths (`DR_WIDTH`=38, `IR_WIDTH`=2).
  - The readback slice-index helper function.
- One sub-module, `nios_debug_scan_shifter`, contains `sr`, `cnt`, the capture mux, the parity generator/checker and `tdo`.
- The command FSM and handshake stay in the top level.

## Test plan
All scenarios use `DR_WIDTH`=8 and `NUM_CH`=4.
- Load `rd_data` slice 2 = 0xA5, set `ir_in`=2, pulse `cdr`, then 8×`sdr` → `tdo` sequence is 1,0,1,0,0,1,0,1 (LSB first).
- Shift in 0x3C LSB first, then `udr` with `ir_in`=1 and `cmd_ready`=0 → `cmd_valid`=4'b0010 and `cmd_data`=0x3C; both held until `cmd_ready[1]`=1, then `cmd_valid`=0 one cycle later.
- Shift 7 bits, then `udr` → `len_err` pulses once; `cmd_valid` stays 0.
- While channel 0 is pending, complete a second valid scan and `udr` → `overrun`=1; `cmd_data` is unchanged; `overrun` stays 1 until reset.
- Assert `udr` and `sdr` in the same cycle → the update takes effect and `cnt`/`sr` do not advance. Then assert reset during `PEND` → all outputs are 0 in the following cycle.
- With the parity macro defined, shift 0x01 with parity bit 0 → `parity_err` pulses and no command is issued. Repeat with parity bit 1 → the command is issued.
